// File: rtl/spi_msg_engine.sv
// Half-duplex multi-lane SPI message engine: shifts in a fixed-length message, waits a
// programmable turnaround, then drives a fixed-length response on the same lines.
module spi_msg_engine #(
  parameter int unsigned LANES      = 1,
  parameter int unsigned MSG_LEN    = 64,
  parameter int unsigned RESP_LEN   = 64,
  parameter int unsigned TURNAROUND = 8
) (
  input  logic                spi_clk,
  input  logic                spi_rst_,
  input  logic [LANES-1:0]    data_in,
  output logic [LANES-1:0]    data_out,
  output logic                data_out_en,
  output logic                msg_valid,
  output logic [MSG_LEN-1:0]  msg,
  input  logic                resp_load,
  input  logic [RESP_LEN-1:0] resp_data,
  output logic                busy
);

  localparam int unsigned N    = MSG_LEN / LANES;
  localparam int unsigned R    = RESP_LEN / LANES;
  localparam int unsigned T    = TURNAROUND;
  localparam int unsigned CMAX = (N > T + R) ? N : T + R;
  localparam int unsigned CW   = (CMAX > 2) ? $clog2(CMAX) : 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : gen_bad_lanes
    $error("spi_msg_engine: LANES must be 1, 2, 4 or 8");
  end
  if ((MSG_LEN % LANES) != 0 || (RESP_LEN % LANES) != 0) begin : gen_bad_len
    $error("spi_msg_engine: MSG_LEN and RESP_LEN must be multiples of LANES");
  end
  if (TURNAROUND < 2) begin : gen_bad_turn
    $error("spi_msg_engine: TURNAROUND must be at least 2");
  end

  typedef enum logic [1:0] {StIdle, StMsg, StTurn, StResp} state_e;

  state_e              state_q;
  logic [CW-1:0]       cnt_q;
  logic [MSG_LEN-1:0]  shift_q;
  logic [RESP_LEN-1:0] resp_q;
  logic [MSG_LEN-1:0]  shift_next;
  logic [RESP_LEN-1:0] resp_next;

  // Response shifts out MSB-first, back-filling with idle-high ones.
  assign shift_next = (shift_q << LANES) | MSG_LEN'(data_in);
  assign resp_next  = (resp_q << LANES) | RESP_LEN'({LANES{1'b1}});
  assign busy       = (state_q != StIdle);

  always_ff @(posedge spi_clk or negedge spi_rst_) begin
    if (!spi_rst_) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      shift_q     <= '0;
      resp_q      <= '1;
      msg         <= '0;
      msg_valid   <= 1'b0;
      data_out    <= '1;
      data_out_en <= 1'b0;
    end else begin
      msg_valid <= 1'b0;
      // The edge after msg_valid is always the first turnaround edge.
      if (msg_valid) begin
        resp_q <= resp_load ? resp_data : '1;
      end
      unique case (state_q)
        StIdle: begin
          if (!data_in[LANES-1]) begin
            shift_q <= shift_next;
            if (N == 1) begin
              msg       <= shift_next;
              msg_valid <= 1'b1;
              state_q   <= StTurn;
              cnt_q     <= CW'(T - 1);
            end else begin
              state_q <= StMsg;
              cnt_q   <= CW'(N - 2);
            end
          end
        end
        StMsg: begin
          shift_q <= shift_next;
          if (cnt_q == '0) begin
            msg       <= shift_next;
            msg_valid <= 1'b1;
            state_q   <= StTurn;
            cnt_q     <= CW'(T - 1);
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StTurn: begin
          if (cnt_q == '0) begin
            data_out    <= resp_q[RESP_LEN-1 -: LANES];
            data_out_en <= 1'b1;
            resp_q      <= resp_next;
            state_q     <= StResp;
            cnt_q       <= CW'(R - 1);
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StResp: begin
          if (cnt_q == '0) begin
            data_out    <= '1;
            data_out_en <= 1'b0;
            state_q     <= StIdle;
          end else begin
            data_out <= resp_q[RESP_LEN-1 -: LANES];
            resp_q   <= resp_next;
            cnt_q    <= cnt_q - 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
